// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hilo_muldiv_ctrl : EX-stage sequencer for the multiplier/divider, owns HI/LO.
// Revision: 1.0
// ----------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ex_hold,
  input  logic        flush,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        stallreq,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;
  localparam logic [2:0] c_mul_lat  = 3'(MUL_LAT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_mul_signed;
  logic        r_div_signed;
  logic [31:0] r_mul_ina;
  logic [31:0] r_mul_inb;
  logic [31:0] r_div_opa;
  logic [31:0] r_div_opb;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic w_take;
  logic w_is_mul;
  logic w_is_div;
  logic w_launch;

  assign w_take   = (r_state == S_IDLE) & op_valid & ~flush;
  assign w_is_mul = (op_code == c_op_mult) | (op_code == c_op_multu);
  assign w_is_div = (op_code == c_op_div) | (op_code == c_op_divu);
  assign w_launch = w_take & (w_is_mul | w_is_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_mul_signed <= 1'b0;
      r_div_signed <= 1'b0;
      r_mul_ina    <= 32'd0;
      r_mul_inb    <= 32'd0;
      r_div_opa    <= 32'd0;
      r_div_opb    <= 32'd0;
      r_hi         <= 32'd0;
      r_lo         <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            case (op_code)
              c_op_mult, c_op_multu: begin
                r_mul_ina    <= src_a;
                r_mul_inb    <= src_b;
                r_mul_signed <= (op_code == c_op_mult);
                r_cnt        <= 3'd1;
                r_state      <= S_MUL_WAIT;
              end
              c_op_div, c_op_divu: begin
                // Divide by zero never reaches the divider; HI/LO are left as they were.
                if (src_b != 32'd0) begin
                  r_div_opa    <= src_a;
                  r_div_opb    <= src_b;
                  r_div_signed <= (op_code == c_op_div);
                  r_state      <= S_DIV_WAIT;
                end else begin
                  r_state <= S_DONE;
                end
              end
              c_op_mthi: r_hi <= src_a;
              c_op_mtlo: r_lo <= src_a;
              default: ;
            endcase
          end
        end
        S_MUL_WAIT: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == c_mul_lat) begin
            r_hi    <= mul_result[63:32];
            r_lo    <= mul_result[31:0];
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_DIV_WAIT: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (div_ready) begin
            r_hi    <= div_result[63:32];
            r_lo    <= div_result[31:0];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Holding in DONE keeps the still-present instruction from relaunching.
          if (flush || !ex_hold) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stallreq   = w_launch | (r_state == S_MUL_WAIT) | (r_state == S_DIV_WAIT);
  assign busy       = (r_state != S_IDLE);
  assign div_start  = (r_state == S_DIV_WAIT) & ~div_ready & ~flush;
  assign div_annul  = (r_state == S_DIV_WAIT) & flush;
  assign mul_signed = r_mul_signed;
  assign mul_ina    = r_mul_ina;
  assign mul_inb    = r_mul_inb;
  assign div_signed = r_div_signed;
  assign div_opa    = r_div_opa;
  assign div_opb    = r_div_opb;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Sequencing controller for the EX-stage multi-cycle arithmetic resources: the pipelined multiplier (mul) and the iterative divider (div, start/ready handshake).
- Launches one operation per EX instruction and holds the pipeline through stallreq until the result is back.
- Owns the architectural HI/LO registers: writes multiplier/divider results and MTHI/MTLO values, and exports HI/LO for MFHI/MFLO.
- Sits beside the ALU in EX; stallreq feeds the central stall controller.

Parameters:
MUL_LAT, 2, cycles from mul_ina/mul_inb valid at the multiplier to mul_result valid (range 1..7).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
op_valid  in  1  EX holds a valid instruction for this block
op_code  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
src_b  in  32  rt operand (divisor / multiplier)
ex_hold  in  1  EX will not take a new instruction at the next edge (stall from a later stage)
flush  in  1  kill the EX instruction this cycle
mul_signed  out  1  to multiplier
mul_ina, mul_inb  out  32 each  registered multiplier operands
mul_result  in  64  {hi, lo} product
div_start, div_signed, div_annul  out  1 each  divider control
div_opa, div_opb  out  32 each  registered divider operands
div_result  in  64  {remainder, quotient}
div_ready  in  1  divider result valid (1-cycle pulse)
stallreq  out  1  stall request to the stall controller
busy  out  1  state is not IDLE
hi_o, lo_o  out  32 each  current HI/LO register values

Behaviour:
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- Reset: state IDLE; HI, LO, operand registers and latency counter 0; every output 0.
- launch = IDLE & op_valid & !flush & op_code in {1..4}.
- stallreq (combinational) = launch | (state == MUL_WAIT) | (state == DIV_WAIT). It is 0 in DONE and 0 for MTHI/MTLO.
- IDLE, op MULT/MULTU on launch:
  - Latch src_a/src_b into mul_ina/mul_inb.
  - mul_signed = (op == MULT), held until DONE.
  - Counter = 1; go to MUL_WAIT.
- MUL_WAIT:
  - Counter increments each cycle.
  - When counter == MUL_LAT: HI <= mul_result[63:32], LO <= mul_result[31:0]; go to DONE.
  - With MUL_LAT = 2: stallreq high for exactly 3 cycles.
- IDLE, op DIV/DIVU on launch:
  - If src_b == 0: no divider start, HI/LO unchanged, go directly to DONE (1 stall cycle).
  - Otherwise latch div_opa/div_opb; div_signed = (op == DIV); go to DIV_WAIT.
- DIV_WAIT:
  - div_start = 1 while div_ready == 0.
  - On div_ready: HI <= div_result[63:32], LO <= div_result[31:0]; div_start = 0; go to DONE.
- DONE:
  - If ex_hold: stay in DONE. Never relaunch the same instruction while it is still held in EX.
  - Otherwise go to IDLE.
  - flush in DONE: go to IDLE.
- MTHI/MTLO (IDLE, op_valid, !flush): HI or LO <= src_a at the edge, no stall. A rewrite while ex_hold repeats the same value, which is harmless.
- Any op_valid while not IDLE is ignored; it is the same held instruction.
- flush in MUL_WAIT or DIV_WAIT:
  - Go to IDLE, no HI/LO write.
  - In DIV_WAIT, div_annul = 1 for that one cycle and div_start = 0.
- flush and div_ready in the same cycle: flush wins, no HI/LO write.
- flush and a launch-eligible op in IDLE: no launch, stallreq 0.
- rst mid-operation: immediate return to IDLE with the reset values above. The divider is reset by the same rst.
- HI/LO writes become visible on hi_o/lo_o the cycle after the write edge. MFHI/MFLO forwarding is outside this block.

Test Plan:
1. MULT, src_a = 0xFFFFFFFD (-3), src_b = 5, no hold -> stallreq high 3 cycles, then hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFF1; MULTU with the same operands -> hi_o = 0x00000004, lo_o = 0xFFFFFFF1.
2. DIVU 100 / 7 -> div_start high until the div_ready pulse, stallreq falls with DONE, hi_o = 2, lo_o = 14; DIV 0xFFFFFFF9 (-7) / 2 -> lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF.
3. DIV with src_b = 0 (HI = 0x11, LO = 0x22 beforehand) -> 1 stall cycle, div_start never asserted, HI/LO unchanged.
4. DIVU launched, flush asserted in the 5th DIV_WAIT cycle -> div_annul pulses for one cycle, state IDLE, HI/LO unchanged; next DIVU 9 / 3 completes with lo_o = 3, hi_o = 0.
5. MULT completes while ex_hold is high for 4 cycles with op_valid and op_code held -> state stays DONE, stallreq 0, exactly one launch, HI/LO written once.
6. MTHI 0xDEADBEEF, then MTLO 0x12345678 on consecutive cycles -> no stallreq, hi_o/lo_o update one cycle after each write; rst asserted during MUL_WAIT -> state IDLE, hi_o = lo_o = 0.
